ctrl_refresh_sched: RTL

Sequences one DDR4 all-bank refresh for each refresh-interval event raised by the controller's refresh counter. Blocks new transactions, drains in-flight work, closes open banks with PREA, issues REF, waits tRFC, then pulses clear_refresh to restart the interval counter. Sits in the controller beside the refresh counter and the command arbiter, and requests the command bus through a valid/grant handshake.

---
 rtl/ddr_pkg.sv | 33 +++
 rtl/ctrl_refresh_sched_if.sv | 12 +
 rtl/ctrl_refresh_timer.sv | 28 ++
 rtl/ctrl_refresh_sched.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared DDR controller types and timing defaults: refresh command codes,
// refresh sequencer states and a counter-width helper.
package ddr_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_PREA = 2'd1,
        CMD_REF  = 2'd2
    } ref_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PRE_REQ,
        PRE_WAIT,
        REF_REQ,
        RFC_WAIT,
        CLEAR
    } ref_state_e;

    // Timing defaults in controller clock cycles.
    localparam int T_RP_DEF   = 15;
    localparam int T_RFC_DEF  = 350;
    localparam int T_REFI_DEF = 7800;

    // Bits needed to hold the larger of two cycle counts without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ctrl_refresh_sched_if.sv
// Refresh-path command request towards the command arbiter (valid/grant).
interface ctrl_refresh_sched_if;
    import ddr_pkg::*;

    logic     ref_cmd_valid;
    ref_cmd_e ref_cmd;
    logic     cmd_grant;

    modport master (output ref_cmd_valid, output ref_cmd, input cmd_grant);
    modport slave  (input ref_cmd_valid, input ref_cmd, output cmd_grant);

endinterface

// File: rtl/ctrl_refresh_timer.sv
// Loadable saturating down-counter shared by the tRP and tRFC waits.
module ctrl_refresh_timer #(
    parameter int W = 9
) (
    input  logic         CK_t,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt;

    // Load wins over counting; stop at zero instead of wrapping.
    always_ff @(posedge CK_t or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
    assign last = (cnt <= W'(1));

endmodule

// File: rtl/ctrl_refresh_sched.sv
// All-bank refresh sequencer: drain traffic, PREA if any bank is open,
// REF, wait tRFC, then pulse clear_refresh to restart the interval counter.
module ctrl_refresh_sched
    import ddr_pkg::*;
#(
    parameter int NUM_BANKS = 16,
    parameter int T_RP      = T_RP_DEF,
    parameter int T_RFC     = T_RFC_DEF,
    parameter int MAX_DRAIN = 64
) (
    input  logic                 CK_t,
    input  logic                 rst,
    input  logic                 refresh_almost,
    input  logic                 refresh_rdy,
    input  logic                 txn_busy,
    input  logic [NUM_BANKS-1:0] bank_open,
    ctrl_refresh_sched_if.master cmd_bus,
    output logic                 refresh_hold,
    output logic                 refresh_active,
    output logic                 clear_refresh,
    output logic                 drain_timeout
);

    localparam int CNT_W = cnt_width((T_RFC > T_RP) ? T_RFC : T_RP, MAX_DRAIN);

    ref_state_e       state, state_nxt;
    logic [CNT_W-1:0] drain_cnt;
    logic             just_cleared;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             tmr_last;

    ctrl_refresh_timer #(.W(CNT_W)) u_timer (
        .CK_t     (CK_t),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero),
        .last     (tmr_last)
    );

    // State register; reset drops straight back to IDLE without a clear pulse.
    always_ff @(posedge CK_t or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Cycles spent in DRAIN, restarted on every entry, saturating.
    always_ff @(posedge CK_t or posedge rst) begin
        if (rst)
            drain_cnt <= '0;
        else if (state != DRAIN)
            drain_cnt <= '0;
        else if (drain_cnt != CNT_W'(MAX_DRAIN))
            drain_cnt <= drain_cnt + 1'b1;
    end

    // Sticky flag once DRAIN has lasted MAX_DRAIN cycles; only reset clears it.
    always_ff @(posedge CK_t or posedge rst) begin
        if (rst)
            drain_timeout <= 1'b0;
        else if (state == DRAIN && drain_cnt == CNT_W'(MAX_DRAIN - 1))
            drain_timeout <= 1'b1;
    end

    // Marks the cycle after CLEAR, while the refresh counter is still
    // dropping its almost/rdy flags, so IDLE does not retrigger on them.
    always_ff @(posedge CK_t or posedge rst) begin
        if (rst)
            just_cleared <= 1'b0;
        else
            just_cleared <= (state == CLEAR);
    end

    // Next state, timer loads and state-decoded outputs.
    always_comb begin
        state_nxt              = state;
        tmr_load               = 1'b0;
        tmr_val                = '0;
        cmd_bus.ref_cmd_valid  = 1'b0;
        cmd_bus.ref_cmd        = CMD_NOP;
        refresh_hold           = (state != IDLE);
        refresh_active         = 1'b0;
        clear_refresh          = 1'b0;
        case (state)
            IDLE: begin
                if (!just_cleared && (refresh_almost || refresh_rdy))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // bank_open only matters here; hold already blocks activates.
                if (refresh_rdy && !txn_busy)
                    state_nxt = (|bank_open) ? PRE_REQ : REF_REQ;
            end
            PRE_REQ: begin
                refresh_active        = 1'b1;
                cmd_bus.ref_cmd_valid = 1'b1;
                cmd_bus.ref_cmd       = CMD_PREA;
                if (cmd_bus.cmd_grant) begin
                    state_nxt = PRE_WAIT;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(T_RP - 1);
                end
            end
            PRE_WAIT: begin
                // Leave one count early so REF is requested exactly T_RP
                // cycles after the PREA grant cycle.
                refresh_active = 1'b1;
                if (tmr_last)
                    state_nxt = REF_REQ;
            end
            REF_REQ: begin
                refresh_active        = 1'b1;
                cmd_bus.ref_cmd_valid = 1'b1;
                cmd_bus.ref_cmd       = CMD_REF;
                if (cmd_bus.cmd_grant) begin
                    state_nxt = RFC_WAIT;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(T_RFC - 1);
                end
            end
            RFC_WAIT: begin
                // Full T_RFC wait cycles before CLEAR.
                refresh_active = 1'b1;
                if (tmr_zero)
                    state_nxt = CLEAR;
            end
            CLEAR: begin
                clear_refresh = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
